// File: rtl/dft16_frame_ctrl.sv
// Frame controller for a 16-point DFT: gathers 16 samples, waits out the datapath
// latency, captures all bins at once and streams them out one per handshake.
module dft16_frame_ctrl #(
    parameter int DFT_LAT   = 4,
    parameter int HALF_SPEC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] in_data,
    output logic [127:0]      x_par,
    output logic              x_valid,
    input  logic [447:0]      r_par,
    input  logic [447:0]      i_par,
    output logic              bin_valid,
    input  logic              bin_ready,
    output logic [3:0]        bin_idx,
    output logic [27:0]       bin_re,
    output logic [27:0]       bin_im,
    output logic              bin_last,
    output logic [15:0]       frames_done
);
    localparam logic [3:0] LAST_BIN = (HALF_SPEC != 0) ? 4'd8 : 4'd15;
    localparam logic [3:0] LAT_END  = 4'(DFT_LAT - 1);

    typedef enum logic [1:0] {FILL, WAIT, CAPTURE} state_t;
    state_t state, state_nxt;

    logic [3:0]  fill_cnt;
    logic [3:0]  lat_cnt;
    logic [7:0]  x_slot  [16];
    logic [27:0] bank_re [16];
    logic [27:0] bank_im [16];
    logic        drain_busy;
    logic        accept;
    logic        bin_xfer;
    logic        drain_done;
    logic        lat_hit;

    assign in_ready   = rst_n && (state == FILL);
    assign accept     = in_valid && in_ready && !flush;
    assign bin_xfer   = drain_busy && bin_ready;
    assign drain_done = bin_xfer && (bin_idx == LAST_BIN);
    assign lat_hit    = (lat_cnt == LAT_END);

    assign bin_valid = drain_busy;
    assign bin_last  = drain_busy && (bin_idx == LAST_BIN);
    assign bin_re    = bank_re[bin_idx];
    assign bin_im    = bank_im[bin_idx];

    always_comb begin
        x_par = '0;
        for (int k = 0; k < 16; k++) x_par[8*k +: 8] = x_slot[k];
    end

    // The capture may coincide with the drain's final transfer; the bank is
    // free again by the time CAPTURE overwrites it.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (accept && fill_cnt == 4'd15) state_nxt = WAIT;
            WAIT:    if (lat_hit && (!drain_busy || drain_done)) state_nxt = CAPTURE;
            CAPTURE: state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
        if (flush) state_nxt = FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            fill_cnt <= '0;
            lat_cnt  <= '0;
            x_valid  <= 1'b0;
            for (int k = 0; k < 16; k++) x_slot[k] <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                fill_cnt <= '0;
                lat_cnt  <= '0;
                x_valid  <= 1'b0;
            end else begin
                if (accept) begin
                    x_slot[fill_cnt] <= in_data;
                    fill_cnt         <= fill_cnt + 4'd1;
                    if (fill_cnt == 4'd15) begin
                        x_valid <= 1'b1;
                        lat_cnt <= '0;
                    end
                end
                if (state == WAIT && !lat_hit) lat_cnt <= lat_cnt + 4'd1;
                if (state == CAPTURE) x_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_busy  <= 1'b0;
            bin_idx     <= '0;
            frames_done <= '0;
            for (int k = 0; k < 16; k++) begin
                bank_re[k] <= '0;
                bank_im[k] <= '0;
            end
        end else begin
            // A final-bin handshake still counts even if flush lands on it.
            if (drain_done) frames_done <= frames_done + 16'd1;
            if (flush) begin
                drain_busy <= 1'b0;
                bin_idx    <= '0;
                for (int k = 0; k < 16; k++) begin
                    bank_re[k] <= '0;
                    bank_im[k] <= '0;
                end
            end else if (state == CAPTURE) begin
                drain_busy <= 1'b1;
                bin_idx    <= '0;
                for (int k = 0; k < 16; k++) begin
                    bank_re[k] <= r_par[28*k +: 28];
                    bank_im[k] <= i_par[28*k +: 28];
                end
            end else if (drain_done) begin
                drain_busy <= 1'b0;
                bin_idx    <= '0;
            end else if (bin_xfer) begin
                bin_idx <= bin_idx + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_dft16_frame_ctrl.sv
// Bench for dft16_frame_ctrl: a full-spectrum instance (latency 4) and a
// half-spectrum instance (latency 1), checked against a frame-level bin model.
module tb_dft16_frame_ctrl;
    localparam int LAT_M = 4;
    localparam int LAT_H = 1;

    typedef struct packed {
        logic [3:0]  idx;
        logic [27:0] re;
        logic [27:0] im;
        logic        last;
    } bin_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush, in_valid, sel, rdy_fix, rdy_rand, rdy_bit;
    logic [7:0] in_data;
    logic bin_ready;
    int   stub_mode;

    logic m_iv, m_in_ready, m_x_valid, m_bin_valid, m_bin_last;
    logic h_iv, h_in_ready, h_x_valid, h_bin_valid, h_bin_last;
    logic [127:0] m_x_par, h_x_par;
    logic [447:0] m_r_par, m_i_par, h_r_par, h_i_par;
    logic [3:0]   m_bin_idx, h_bin_idx;
    logic [27:0]  m_bin_re, m_bin_im, h_bin_re, h_bin_im;
    logic [15:0]  m_frames_done, h_frames_done;
    int m_vcnt, h_vcnt;

    logic in_ready_s, x_valid_s, bin_valid_s, bin_last_s;
    logic [127:0] x_par_s;
    logic [3:0]   bin_idx_s;
    logic [27:0]  bin_re_s, bin_im_s;
    logic [15:0]  frames_done_s;

    int n_tot = 0, n_pass = 0, n_fail = 0;
    logic [7:0]   mdl_x [16];
    int           mdl_n = 0;
    logic [127:0] mdl_xpar = '0;
    bin_t exp_q[$];
    bin_t obs_q[$];

    always #5 clk = ~clk;

    assign m_iv       = in_valid & ~sel;
    assign h_iv       = in_valid & sel;
    assign bin_ready  = rdy_rand ? rdy_bit : rdy_fix;
    assign in_ready_s    = sel ? h_in_ready    : m_in_ready;
    assign x_valid_s     = sel ? h_x_valid     : m_x_valid;
    assign x_par_s       = sel ? h_x_par       : m_x_par;
    assign bin_valid_s   = sel ? h_bin_valid   : m_bin_valid;
    assign bin_last_s    = sel ? h_bin_last    : m_bin_last;
    assign bin_idx_s     = sel ? h_bin_idx     : m_bin_idx;
    assign bin_re_s      = sel ? h_bin_re      : m_bin_re;
    assign bin_im_s      = sel ? h_bin_im      : m_bin_im;
    assign frames_done_s = sel ? h_frames_done : m_frames_done;

    dft16_frame_ctrl #(.DFT_LAT(LAT_M), .HALF_SPEC(0)) u_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(m_iv), .in_ready(m_in_ready),
        .in_data(in_data), .x_par(m_x_par), .x_valid(m_x_valid), .r_par(m_r_par),
        .i_par(m_i_par), .bin_valid(m_bin_valid), .bin_ready(bin_ready), .bin_idx(m_bin_idx),
        .bin_re(m_bin_re), .bin_im(m_bin_im), .bin_last(m_bin_last), .frames_done(m_frames_done)
    );

    dft16_frame_ctrl #(.DFT_LAT(LAT_H), .HALF_SPEC(1)) u_h (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(h_iv), .in_ready(h_in_ready),
        .in_data(in_data), .x_par(h_x_par), .x_valid(h_x_valid), .r_par(h_r_par),
        .i_par(h_i_par), .bin_valid(h_bin_valid), .bin_ready(bin_ready), .bin_idx(h_bin_idx),
        .bin_re(h_bin_re), .bin_im(h_bin_im), .bin_last(h_bin_last), .frames_done(h_frames_done)
    );

    // Stub datapath results: bin k derived from the slots, garbage until DFT_LAT
    // cycles of stable x_par have elapsed.
    function automatic logic [27:0] f_re(input int k, input logic [127:0] xp, input int mode);
        logic [7:0] b;
        b = xp[8*k +: 8];
        if (mode == 0) return 28'(k * 1000);
        return 28'(k * 1000 + int'($signed(b)) * (k + 1) - 3);
    endfunction

    function automatic logic [27:0] f_im(input int k, input logic [127:0] xp, input int mode);
        logic [7:0] b;
        b = xp[8*(15-k) +: 8];
        if (mode == 0) return 28'(-k);
        return 28'(-(int'($signed(b)) * 7) - 5 * k);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vcnt <= 0;
            h_vcnt <= 0;
        end else begin
            m_vcnt <= m_x_valid ? ((m_vcnt < 100) ? m_vcnt + 1 : m_vcnt) : 0;
            h_vcnt <= h_x_valid ? ((h_vcnt < 100) ? h_vcnt + 1 : h_vcnt) : 0;
        end
    end

    always_comb begin
        m_r_par = '0; m_i_par = '0; h_r_par = '0; h_i_par = '0;
        for (int k = 0; k < 16; k++) begin
            m_r_par[28*k +: 28] = (m_vcnt >= LAT_M) ? f_re(k, m_x_par, stub_mode) : 28'h5A5A5A5;
            m_i_par[28*k +: 28] = (m_vcnt >= LAT_M) ? f_im(k, m_x_par, stub_mode) : 28'hA5A5A5A;
            h_r_par[28*k +: 28] = (h_vcnt >= LAT_H) ? f_re(k, h_x_par, stub_mode) : 28'h5A5A5A5;
            h_i_par[28*k +: 28] = (h_vcnt >= LAT_H) ? f_im(k, h_x_par, stub_mode) : 28'hA5A5A5A;
        end
    end

    always @(negedge clk) rdy_bit <= 1'($urandom);

    always @(posedge clk) begin
        if (rst_n && bin_valid_s && bin_ready)
            obs_q.push_back(bin_t'({bin_idx_s, bin_re_s, bin_im_s, bin_last_s}));
    end

    task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] d);
        int nb;
        mdl_x[mdl_n] = d;
        mdl_n++;
        if (mdl_n == 16) begin
            mdl_n = 0;
            for (int k = 0; k < 16; k++) mdl_xpar[8*k +: 8] = mdl_x[k];
            nb = sel ? 9 : 16;
            for (int k = 0; k < nb; k++)
                exp_q.push_back(bin_t'({4'(k), f_re(k, mdl_xpar, stub_mode),
                                        f_im(k, mdl_xpar, stub_mode), k == nb - 1}));
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the last accept.
    task automatic feed(input int cnt, input int mode, input logic [7:0] base, input bit gaps);
        for (int i = 0; i < cnt; i++) begin
            logic [7:0] d;
            int w;
            d = (mode == 0) ? base + 8'(i) : 8'($urandom);
            for (int g = 0; gaps && g < 3 && $urandom_range(0, 1) == 1; g++) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = d;
            w = 0;
            while (!in_ready_s && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready_s) begin
                chk(0, 1, "feed_timeout");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            model_accept(d);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_fd(input logic [15:0] target);
        int w;
        w = 0;
        while (frames_done_s != target && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk(frames_done_s, target, "frames_done");
    endtask

    task automatic cmp_bins(input string tag);
        chk(obs_q.size(), exp_q.size(), {tag, "_count"});
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk(obs_q.pop_front(), exp_q.pop_front(), tag);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic wait_bin(input logic [3:0] idx, input bit want_last);
        int w;
        w = 0;
        while (!(bin_valid_s && (want_last ? bin_last_s : bin_idx_s == idx)) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk(bin_valid_s, 1, "wait_bin");
    endtask

    task automatic watch_quiet(input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | bin_valid_s;
        end
        chk(seen, 0, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e, w;
        logic [15:0] fd0;
        logic seen;
        bin_t b0;
        flush = 0; in_valid = 0; in_data = 0; sel = 0;
        rdy_fix = 1; rdy_rand = 0; stub_mode = 0;
        #1 rst_n = 1'b0;
        #11;
        chk(in_ready_s, 0, "rst_in_ready");
        chk(x_valid_s, 0, "rst_x_valid");
        chk(x_par_s, 0, "rst_x_par");
        chk({bin_valid_s, bin_last_s, bin_idx_s}, 0, "rst_bin_ctl");
        chk({bin_re_s, bin_im_s}, 0, "rst_bin_data");
        chk(frames_done_s, 0, "rst_frames_done");
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk(in_ready_s, 1, "rel_in_ready");
        @(negedge clk);

        // Samples 0..15, bin k = k*1000, capture timing.
        feed(16, 0, 8'h00, 0);
        chk(x_valid_s, 1, "a_x_valid");
        chk(x_par_s[7:0], 8'h00, "a_x0");
        chk(x_par_s[127:120], 8'h0F, "a_x15");
        chk(x_par_s, mdl_xpar, "a_xpar");
        chk(in_ready_s, 0, "a_in_ready_wait");
        e = 0; seen = 0;
        while (!seen && e < 40) begin
            @(posedge clk);
            #1;
            e++;
            seen = bin_valid_s;
        end
        chk(e, LAT_M + 1, "a_capture_edge");
        @(negedge clk);
        wait_fd(16'd1);
        chk(bin_valid_s, 0, "a_valid_drop");
        cmp_bins("a_bin");

        // Drain stalled while the next frame fills; frame order preserved.
        stub_mode = 1;
        rdy_fix = 0;
        fd0 = frames_done_s;
        feed(16, 1, 8'h00, 0);
        w = 0;
        while (!bin_valid_s && w < 50) begin
            @(negedge clk);
            w++;
        end
        b0 = (exp_q.size() > 0) ? exp_q[0] : '0;
        feed(16, 1, 8'h00, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk({bin_valid_s, bin_idx_s, bin_re_s, bin_im_s}, {1'b1, 4'd0, b0.re, b0.im}, "b_hold");
        end
        chk(in_ready_s, 0, "b_stall_in_ready");
        chk(x_valid_s, 1, "b_stall_x_valid");
        rdy_fix = 1;
        wait_fd(fd0 + 16'd2);
        cmp_bins("b_bin");

        // Random in_valid gaps and random bin_ready.
        rdy_rand = 1;
        fd0 = frames_done_s;
        feed(16, 0, 8'hF0, 1);
        chk(x_par_s[127:120], 8'hFF, "c_x15");
        chk(x_par_s, mdl_xpar, "c_xpar");
        for (int f = 0; f < 3; f++) feed(16, 1, 8'h00, 1);
        wait_fd(fd0 + 16'd4);
        cmp_bins("c_bin");
        rdy_rand = 0;
        @(negedge clk);

        // Flush after 7 samples, with a sample offered in the flush cycle.
        fd0 = frames_done_s;
        feed(7, 1, 8'h00, 0);
        flush = 1; in_valid = 1; in_data = 8'h33;
        @(negedge clk);
        flush = 0; in_valid = 0;
        mdl_n = 0;
        chk(x_valid_s, 0, "d_x_valid");
        chk(in_ready_s, 1, "d_in_ready");
        chk(frames_done_s, fd0, "d_fd_after_flush");
        feed(16, 0, 8'h80, 0);
        chk(x_par_s[7:0], 8'h80, "d_x0");
        chk(x_par_s, mdl_xpar, "d_xpar");
        wait_fd(fd0 + 16'd1);
        cmp_bins("d_bin");

        // Flush in the middle of a drain.
        fd0 = frames_done_s;
        feed(16, 1, 8'h00, 0);
        wait_bin(4'd3, 0);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk(bin_valid_s, 0, "e_valid_flush");
        chk(frames_done_s, fd0, "e_fd_flush");
        watch_quiet(20, "e_no_output");
        exp_q.delete();
        obs_q.delete();

        // Flush coinciding with the final-bin transfer still counts the frame.
        fd0 = frames_done_s;
        feed(16, 1, 8'h00, 0);
        wait_bin(4'd15, 1);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk(frames_done_s, fd0 + 16'd1, "f_fd_flush_last");
        chk(bin_valid_s, 0, "f_valid_drop");
        cmp_bins("f_bin");

        // Reset mid-drain at bin 5.
        feed(16, 1, 8'h00, 0);
        wait_bin(4'd5, 0);
        rst_n = 1'b0;
        #1;
        chk(bin_valid_s, 0, "g_rst_valid");
        chk(frames_done_s, 0, "g_rst_fd");
        chk({x_valid_s, bin_idx_s}, 0, "g_rst_ctl");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk(in_ready_s, 1, "g_rel_in_ready");
        watch_quiet(20, "g_no_output");
        exp_q.delete();
        obs_q.delete();
        mdl_n = 0;

        // Half-spectrum instance with single-cycle latency.
        sel = 1;
        @(negedge clk);
        feed(16, 1, 8'h00, 0);
        chk(x_par_s, mdl_xpar, "h_xpar");
        e = 0; seen = 0;
        while (!seen && e < 40) begin
            @(posedge clk);
            #1;
            e++;
            seen = bin_valid_s;
        end
        chk(e, LAT_H + 1, "h_capture_edge");
        @(negedge clk);
        wait_fd(16'd1);
        chk(bin_valid_s, 0, "h_valid_drop");
        cmp_bins("h_bin");
        watch_quiet(10, "h_no_extra");
        chk(obs_q.size(), 0, "h_no_extra_bins");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/dft16_frame_ctrl.md
DFT16_FRAME_CTRL -- requirements
Module: dft16_frame_ctrl

Interface
REQ-001 SHALL have parameter DFT_LAT, default 4: the number of clk cycles from x_par becoming stable until r_par/i_par are valid. Legal range is 1..15.
REQ-002 SHALL have parameter HALF_SPEC, default 0. When 1, only bins 0..8 are emitted. When 0, bins 0..15 are emitted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of the current frame and the current drain.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 8, signed): the sample stream handshake.
REQ-007 SHALL have ports x_par (output, 128) and x_valid (output, 1). x_par carries the parallel X0..X15 to the DFT datapath, with X0 in bits [7:0] and Xk in bits [8k+7:8k].
REQ-008 SHALL have ports r_par (input, 448) and i_par (input, 448): the DFT results, with bin k in bits [28k+27:28k], two's complement.
REQ-009 SHALL have ports bin_valid (output, 1), bin_ready (input, 1), bin_idx (output, 4), bin_re (output, 28), bin_im (output, 28) and bin_last (output, 1): the bin output stream.
REQ-010 SHALL have port frames_done, output, 16 bits: the count of fully drained frames.

Function
REQ-011 SHALL implement an input FSM with states FILL, WAIT and CAPTURE, plus an independent drain engine.
REQ-012 SHALL, in FILL:
- assert in_ready = 1;
- on in_valid & in_ready, write in_data into slot Xn, where n is a 4-bit fill counter, and increment n.
REQ-013 SHALL, on acceptance of the sample with n = 15, go to WAIT, set x_valid = 1, clear the latency counter and wrap n to 0.
REQ-014 SHALL hold in_ready = 0 and keep x_par unchanged throughout WAIT and CAPTURE.
REQ-015 SHALL, in WAIT, increment the latency counter each cycle. The FSM SHALL go to CAPTURE once the count equals DFT_LAT-1 and the drain engine is idle (or finishes its last bin in that same cycle).
REQ-016 SHALL, if the count has reached DFT_LAT-1 but the drain is busy, stay in WAIT (stalled) with the counter saturated.
REQ-017 SHALL, in CAPTURE (one cycle), latch all 16 re/im bins from r_par/i_par into the output bank, start the drain at bin 0, clear x_valid and return to FILL.
REQ-018 SHALL set the capture edge with no stall at exactly DFT_LAT+1 rising edges after the edge that accepts the 16th sample.
REQ-019 SHALL, in the drain engine:
- present bin_valid = 1 with bin_idx, bin_re and bin_im from the bank;
- advance bin_idx on bin_valid & bin_ready;
- hold bin_re and bin_im stable while bin_valid = 1 and bin_ready = 0.
REQ-020 SHALL assert bin_last = 1 with the final bin: bin 8 if HALF_SPEC = 1, otherwise bin 15. On transfer of the final bin, bin_valid SHALL drop the next cycle and frames_done SHALL increment, wrapping 0xFFFF to 0x0000.
REQ-021 SHALL allow FILL of the next frame to proceed concurrently with the drain.
REQ-022 SHALL, when flush = 1:
- on the next edge, enter FILL with n = 0 and x_valid = 0, and drop bin_valid;
- discard the bank and do not increment frames_done;
- give flush priority over a simultaneous sample acceptance, which is dropped.
REQ-023 SHALL, if flush and a final-bin transfer occur in the same cycle, count the transfer: frames_done increments.
REQ-024 SHALL pass bin_re and bin_im through without modification; no arithmetic is performed on results.

Reset
REQ-025 SHALL, while rst_n = 0, immediately force the following:
- FSM = FILL, n = 0, latency counter = 0;
- in_ready = 0 during reset, then 1 in the first cycle after deassertion;
- x_valid = 0, x_par = 0;
- bin_valid = 0, bin_last = 0, bin_idx = 0, bin_re = 0, bin_im = 0;
- frames_done = 0, output bank = 0.
REQ-026 SHALL, if reset asserts mid-frame or mid-drain, discard all partial state, with no output after release until a new full frame is captured.

Verification
REQ-027 SHALL be covered by a bench case: DFT_LAT = 4; feed samples 0..15 back to back; stub r_par bin k = k*1000 -> x_par[7:0] = 0x00, x_par[127:120] = 0x0F, x_valid high; capture on edge 5 after the 16th accept; bins 0..15 out with bin_re = 0, 1000..15000; bin_last on bin 15; frames_done = 1.
REQ-028 SHALL be covered by a bench case: HALF_SPEC = 1, bin_ready always 1 -> exactly 9 bins (idx 0..8); bin_last with idx 8; bin_valid low the next cycle.
REQ-029 SHALL be covered by a bench case: bin_ready = 0 held for 40 cycles while the second frame fills -> second frame stalls in WAIT, in_ready = 0, bin 0 of frame 1 stable; after release all 16 bins of frame 1 precede any bin of frame 2.
REQ-030 SHALL be covered by a bench case: flush after 7 samples, then 16 samples 0x80..0x8F -> x_par[7:0] = 0x80 (the first 7 are discarded); frames_done is not incremented by the flush.
REQ-031 SHALL be covered by a bench case: rst_n low for 2 cycles during drain at bin 5 -> bin_valid = 0 and frames_done = 0 immediately; in_ready = 1 in the first cycle after release.
REQ-032 SHALL be covered by a bench case: in_valid toggling randomly with the 16 samples 0xF0..0xFF -> only accepted samples fill slots in order, giving x_par[127:120] = 0xFF.
